srl_delay_vw: RTL and testbench

- Parametrised successor of the fixed 64-bit, 1-bit-wide adjustable-length shift register.
- Provides a W-bit-wide, DEPTH-deep, clock-enabled delay line with run-time tap select, a priming/valid flag, zero-fill masking, a synchronous flush, and an optional output register.
- Used in the DSP datapath for sample alignment (I/Q skew, filter-tap matching) where the delay must be reprogrammed without a reset.

---
 rtl/srl_delay_vw_if.sv | 26 ++
 rtl/srl_delay_vw.sv | 114 +++++++++++
 tb/tb_srl_delay_vw.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/srl_delay_vw_if.sv
// Bus bundle for the variable-tap delay line: sample/control inputs from the
// producer side and tap/cascade/fill outputs back to it.
interface srl_delay_vw_if #(
  parameter int W  = 16,
  parameter int AW = 6
);
  logic          CE;
  logic          CLR;
  logic [W-1:0]  D;
  logic [AW-1:0] A;
  logic [W-1:0]  Q;
  logic          QV;
  logic [W-1:0]  QL;
  logic          QLV;
  logic [AW:0]   FILL;

  modport master (
    output CE, CLR, D, A,
    input  Q, QV, QL, QLV, FILL
  );

  modport slave (
    input  CE, CLR, D, A,
    output Q, QV, QL, QLV, FILL
  );
endinterface

// File: rtl/srl_delay_vw.sv
// W-bit, 2**AW-deep clock-enabled delay line with run-time tap select.
// Storage is a circular buffer indexed by a write pointer; the tap at delay
// A+1 sits A+1 slots behind the pointer. A fill counter tracks how many
// stages hold samples written since reset/flush and drives the valid flags
// and optional zero-fill masking. Storage itself is never reset.
module srl_delay_vw #(
  parameter int W     = 16,
  parameter int AW    = 6,
  parameter int OREG  = 0,
  parameter int ZFILL = 1
) (
  input  logic           CLK,
  input  logic           RST_N,
  srl_delay_vw_if.slave  bus
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW:0]   fill_q, fill_d;
  logic          wr_en;

  logic [AW-1:0] rd_idx;
  logic [W-1:0]  tap_raw, tap_val;
  logic          tap_vld;
  logic [W-1:0]  last_raw, last_val;
  logic          last_vld;

  // CLR takes priority over CE: a flush never writes.
  assign wr_en = bus.CE & ~bus.CLR;

  // Next write pointer and saturating fill count.
  always_comb begin
    wp_d   = wp_q;
    fill_d = fill_q;
    if (bus.CLR) begin
      fill_d = '0;
    end else if (bus.CE) begin
      wp_d = wp_q + AW'(1);
      if (fill_q != DEPTH_C) begin
        fill_d = fill_q + (AW+1)'(1);
      end
    end
  end

  // Pointer and fill state, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp_q   <= '0;
      fill_q <= '0;
    end else begin
      wp_q   <= wp_d;
      fill_q <= fill_d;
    end
  end

  // Sample storage; contents survive reset and flush by design.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wp_q] <= bus.D;
    end
  end

  // Tap and oldest-stage reads with optional masking of stale stages.
  always_comb begin
    rd_idx   = wp_q - AW'(1) - bus.A;
    tap_raw  = mem_q[rd_idx];
    tap_vld  = (fill_q > {1'b0, bus.A});
    tap_val  = tap_raw;
    if (ZFILL != 0 && !tap_vld) begin
      tap_val = '0;
    end
    last_raw = mem_q[wp_q];
    last_vld = (fill_q == DEPTH_C);
    last_val = last_raw;
    if (ZFILL != 0 && !last_vld) begin
      last_val = '0;
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [W-1:0] q_q;
      logic         qv_q;

      // Registered tap stage, advanced only on CE edges and cleared by flush.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          q_q  <= '0;
          qv_q <= 1'b0;
        end else if (bus.CLR) begin
          q_q  <= '0;
          qv_q <= 1'b0;
        end else if (bus.CE) begin
          q_q  <= tap_val;
          qv_q <= tap_vld;
        end
      end

      assign bus.Q  = q_q;
      assign bus.QV = qv_q;
    end else begin : g_comb
      assign bus.Q  = tap_val;
      assign bus.QV = tap_vld;
    end
  endgenerate

  assign bus.QL   = last_val;
  assign bus.QLV  = last_vld;
  assign bus.FILL = fill_q;

endmodule

// File: tb/tb_srl_delay_vw.sv
// Random and directed stimulus for the delay line, run on an unregistered and
// a registered-output build side by side against a sample-history model.
module tb_srl_delay_vw;
  localparam int W     = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          CLK   = 1'b0;
  logic          RST_N = 1'b0;
  logic          ce    = 1'b0;
  logic          clr   = 1'b0;
  logic [W-1:0]  d     = '0;
  logic [AW-1:0] a     = '0;

  srl_delay_vw_if #(.W(W), .AW(AW)) bus0 ();
  srl_delay_vw_if #(.W(W), .AW(AW)) bus1 ();

  assign bus0.CE  = ce;
  assign bus0.CLR = clr;
  assign bus0.D   = d;
  assign bus0.A   = a;
  assign bus1.CE  = ce;
  assign bus1.CLR = clr;
  assign bus1.D   = d;
  assign bus1.A   = a;

  srl_delay_vw #(.W(W), .AW(AW), .OREG(0), .ZFILL(1)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus0)
  );
  srl_delay_vw #(.W(W), .AW(AW), .OREG(1), .ZFILL(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus1)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: hist[0] is the most recent sample written, hist[k] was written
  // k+1 CE edges ago. m_fill counts samples written since reset/flush.
  logic [W-1:0] hist[$];
  int           m_fill = 0;
  logic [W-1:0] m_oq   = '0;
  logic         m_oqv  = 1'b0;

  function automatic logic [W-1:0] tap_exp(input int idx);
    if (m_fill > idx) return hist[idx];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q0"},    32'(bus0.Q),    32'(tap_exp(int'(a))));
    chk({tag, ".qv0"},   32'(bus0.QV),   32'(m_fill > int'(a)));
    chk({tag, ".ql0"},   32'(bus0.QL),   32'(tap_exp(DEPTH - 1)));
    chk({tag, ".qlv0"},  32'(bus0.QLV),  32'(m_fill == DEPTH));
    chk({tag, ".fill0"}, 32'(bus0.FILL), 32'(m_fill));
    chk({tag, ".q1"},    32'(bus1.Q),    32'(m_oq));
    chk({tag, ".qv1"},   32'(bus1.QV),   32'(m_oqv));
    chk({tag, ".ql1"},   32'(bus1.QL),   32'(tap_exp(DEPTH - 1)));
    chk({tag, ".fill1"}, 32'(bus1.FILL), 32'(m_fill));
  endtask

  // Apply one clock edge to the model with the current inputs, then check.
  task automatic tick(input string tag);
    if (clr) begin
      m_fill = 0;
      m_oq   = '0;
      m_oqv  = 1'b0;
    end else if (ce) begin
      m_oq  = tap_exp(int'(a));
      m_oqv = (m_fill > int'(a));
      hist.push_front(d);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      if (m_fill < DEPTH) m_fill++;
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset between edges; released on the falling edge.
  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    m_fill = 0;
    m_oq   = '0;
    m_oqv  = 1'b0;
    check_all("arst");
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #2;
    check_all("por");
    @(negedge CLK);
    RST_N = 1'b1;

    // Priming with A=5: valid after the 6th edge.
    a  = 6'd5;
    ce = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      d = W'(k);
      tick("prime");
    end

    // Fill saturation and wrap-around with A=63.
    clr = 1'b1;
    tick("flush1");
    clr = 1'b0;
    a   = 6'd63;
    for (int k = 1; k <= 100; k++) begin
      d = W'(k);
      tick("wrap");
    end
    chk("wrap.q37", 32'(bus0.Q), 32'd37);
    chk("wrap.ql37", 32'(bus0.QL), 32'd37);

    // Delay counts CE edges only.
    a = 6'd2;
    for (int i = 0; i < 12; i++) begin
      ce = (i % 2 == 0);
      d  = W'($urandom);
      tick("cetog");
    end

    // Flush with CE high from a full line; the flush-edge sample is dropped.
    a   = 6'd10;
    ce  = 1'b1;
    clr = 1'b1;
    d   = 16'hdead;
    tick("clrce");
    clr = 1'b0;
    for (int i = 0; i < 13; i++) begin
      d = W'($urandom);
      tick("postclr");
    end

    // Growing A past FILL-1 mid-stream.
    clr = 1'b1;
    tick("flush2");
    clr = 1'b0;
    a   = 6'd3;
    for (int i = 0; i < 20; i++) begin
      d = W'($urandom);
      tick("fill20");
    end
    a = 6'd40;
    #1;
    check_all("aswitch");
    for (int i = 0; i < 25; i++) begin
      d = W'($urandom);
      tick("regrow");
    end

    // Mid-stream asynchronous reset and recovery.
    do_reset();
    a = 6'd5;
    for (int k = 1; k <= 8; k++) begin
      d = W'(k);
      tick("recover");
    end

    // Randomised run.
    for (int i = 0; i < 3000; i++) begin
      ce  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 59) == 0);
      d   = W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        a = AW'($urandom);
        #1;
        check_all("acomb");
      end
      if ($urandom_range(0, 799) == 0) do_reset();
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
